sparc_exu_ecc_chk: RTL
======================

# sparc_exu_ecc_chk

Two-stage pipelined SEC-DED checker/corrector for 64-bit data protected by the 8-bit check code produced by the EXU bypass ECC generator. It sits on the register-file read path and recomputes the syndrome. It corrects any single-bit data error, flags single check-bit errors as correctable, and flags double-bit errors as uncorrectable. It also keeps saturating error counters and a first-error log for the trap and diagnostic logic.

## Interface
- No parameters; widths are fixed by the code (64 data, 8 check).
- clk  in  1  core clock
- rst_l  in  1  synchronous active-low reset
- se  in  1  scan enable to all flops; no functional effect
- vld_in  in  1  d_in/p_in valid this cycle
- d_in  in  64  received data
- p_in  in  8  received check bits
- log_clr  in  1  clear log and counters
- vld_out  out  1  outputs valid
- d_out  out  64  corrected data
- syn  out  8  syndrome {s7, s[6:0]}
- ce  out  1  correctable error
- ue  out  1  uncorrectable error
- log_vld  out  1  log holds an error
- log_syn  out  8  logged syndrome
- log_ue  out  1  logged error was UE
- ce_cnt  out  8  saturating CE count
- ue_cnt  out  8  saturating UE count

## Operation
- Code map:
  - Codeword positions are 1..71. Check bit k (k=0..6) sits at position 2^k.
  - Data bit i sits at the i-th non-power-of-two position ≥3 (d0→3, d1→5, d2→6, d3→7, d4→9 … d57..d63→65..71).
  - p[k] (k≤6) is the XOR of the data bits whose position has bit k set.
  - p[7] makes the XOR of all 72 stored bits equal 0.
- Syndrome:
  - s[6:0] = recomputed p[6:0] ^ p_in[6:0].
  - s7 = XOR of all 64 data bits and all 8 check bits.
- Classification, evaluated only when the stage-2 valid is set:
  - s==0: clean.
  - s7=1 and s[6:0] is 0 or a power of two: check-bit error. ce=1, data unchanged.
  - s7=1 and s[6:0] is a data position 3..71: flip that data bit. ce=1.
  - s7=1 and s[6:0]>71: ue=1.
  - s7=0 and s[6:0]!=0: ue=1.
  - On ue, data passes through uncorrected.
- ce and ue are never both 1. Both are 0 whenever vld_out=0.
- Counters:
  - ce_cnt increments on each vld_out&ce; ue_cnt increments on each vld_out&ue.
  - Both saturate at 255.
- Log:
  - Loads syn and log_ue on the first error while log_vld=0.
  - A UE overwrites a logged CE. A CE never overwrites a log entry. A UE never overwrites a logged UE.
- log_clr:
  - Zeros the log and both counters.
  - If an error is captured in the same cycle, the new error wins: log is loaded with it, its counter becomes 1, the other counter becomes 0.

## Timing
- Stage 1 (edge after the input cycle N) registers d_in, p_in, vld_in and 16 partial XOR groups.
- Stage 2 (edge N+2) registers d_out, syn, ce, ue, vld_out, counters and log.
- Latency is exactly 2 cycles with full throughput: a new input is accepted every cycle and there is no backpressure.
- syn and d_out update on every stage-2 edge regardless of validity; consumers qualify them with vld_out.
- Reset (rst_l=0 at an edge) clears all outputs and internal valids to 0.
- An input in flight when reset is asserted is discarded; no vld_out is produced for it.
- The first valid output appears 2 cycles after the first post-reset vld_in.

## Configuration
- SPARC_ECC_ERR_LOG_EN
  - Defined: counters and the log are present as described.
  - Undefined: the counter and log flops are not built. log_vld, log_syn, log_ue, ce_cnt and ue_cnt are tied to 0, log_clr is ignored, and the data path is unaffected.

## Structure
- Package sparc_ecc_pkg holds:
  - data and check width constants;
  - eight 64-bit parity-mask constants, one per check bit;
  - a position-to-data-index constant table covering positions 0..127, with non-data entries marked invalid.
- Sub-module sparc_exu_ecc_syndec is a combinational decoder: from the 8-bit syndrome it produces a 64-bit flip mask plus ce/ue. It is instantiated between stage 1 and stage 2.

## Test plan
- d_in=0, p_in=8'h00, vld_in=1 → 2 cycles later: vld_out=1, d_out=0, syn=0, ce=ue=0.
- d_in=0, p_in=8'h83 (d0 flipped from codeword d=1) → d_out=64'h1, syn=8'h83, ce=1, ce_cnt=1, log_syn=8'h83.
- d_in=0, p_in=8'h01 → syn=8'h81, ce=1, d_out=0.
- d_in=0, p_in=8'h03 → syn=8'h03, ue=1, d_out=0; the logged CE is replaced and log_ue=1.
- 300 back-to-back single-bit errors → ce_cnt=255 and holds. Then log_clr with no error → all log and counter outputs 0 next cycle.
- vld_in=1 at cycle N, rst_l=0 at N+1 → vld_out stays 0 through N+3.

Source files
------------

// File: rtl/sparc_ecc_pkg.sv
// Shared constants for the EXU SEC-DED (72,64) code: widths, per-check-bit parity
// masks and the syndrome-position to data-index table, all derived from the code map.
package sparc_ecc_pkg;

  localparam int DATA_W  = 64;
  localparam int CHK_W   = 8;
  localparam int POS_NUM = 128;

  typedef logic [CHK_W-1:0][DATA_W-1:0] mask_tab_t;
  // Each entry is {valid, data_index[5:0]}.
  typedef logic [POS_NUM-1:0][6:0]      idx_tab_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CHK,
    ERR_DATA,
    ERR_UNCORR
  } err_class_e;

  // Codeword position of data bit idx: the idx-th non-power-of-two position >= 3.
  function automatic logic [6:0] data_pos(int idx);
    int n;
    logic [6:0] pos;
    n   = 0;
    pos = '0;
    for (int p = 3; p < POS_NUM; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) pos = 7'(p);
        n++;
      end
    end
    return pos;
  endfunction

  // Mask 7 folds the overall-parity bit onto data only: a data bit lands in p7
  // when it is not already covered by an odd number of p[6:0] bits.
  function automatic mask_tab_t build_masks();
    mask_tab_t m;
    logic [6:0] pos;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pos = data_pos(i);
      for (int k = 0; k < 7; k++) m[k][i] = pos[k];
      m[7][i] = ~(^pos);
    end
    return m;
  endfunction

  function automatic idx_tab_t build_idx_tab();
    idx_tab_t t;
    t = '0;
    for (int i = 0; i < DATA_W; i++) t[data_pos(i)] = {1'b1, 6'(i)};
    return t;
  endfunction

  localparam mask_tab_t PAR_MASK = build_masks();
  localparam idx_tab_t  POS2IDX  = build_idx_tab();

endpackage

// File: rtl/sparc_exu_ecc_chk_if.sv
// Read-path bus of the ECC checker: received word in, corrected word, status,
// error counters and first-error log out.
interface sparc_exu_ecc_chk_if;
  import sparc_ecc_pkg::*;

  logic              vld_in;
  logic [DATA_W-1:0] d_in;
  logic [CHK_W-1:0]  p_in;
  logic              log_clr;
  logic              vld_out;
  logic [DATA_W-1:0] d_out;
  logic [CHK_W-1:0]  syn;
  logic              ce;
  logic              ue;
  logic              log_vld;
  logic [CHK_W-1:0]  log_syn;
  logic              log_ue;
  logic [7:0]        ce_cnt;
  logic [7:0]        ue_cnt;

  modport master (
    output vld_in, d_in, p_in, log_clr,
    input  vld_out, d_out, syn, ce, ue, log_vld, log_syn, log_ue, ce_cnt, ue_cnt
  );

  modport slave (
    input  vld_in, d_in, p_in, log_clr,
    output vld_out, d_out, syn, ce, ue, log_vld, log_syn, log_ue, ce_cnt, ue_cnt
  );

endinterface

// File: rtl/sparc_exu_ecc_syndec.sv
// Combinational SEC-DED syndrome decoder: classifies the 8-bit syndrome and
// produces a one-hot data flip mask for correctable data-bit errors.
module sparc_exu_ecc_syndec
  import sparc_ecc_pkg::*;
(
  input  logic [CHK_W-1:0]  i_syn,
  output logic [DATA_W-1:0] o_flip,
  output logic              o_ce,
  output logic              o_ue
);

  err_class_e w_class;
  logic [6:0] w_pos;
  logic [6:0] w_entry;

  assign w_pos   = i_syn[6:0];
  assign w_entry = POS2IDX[w_pos];

  // NOTE: every always_comb output gets a default first so no path can hold a value (latch).
  always_comb begin
    w_class = ERR_NONE;
    if (i_syn != '0) begin
      if (!i_syn[7])                         w_class = ERR_UNCORR;
      else if ((w_pos & (w_pos - 7'd1)) == '0) w_class = ERR_CHK;
      else if (w_entry[6])                   w_class = ERR_DATA;
      else                                   w_class = ERR_UNCORR;
    end
  end

  always_comb begin
    o_flip = '0;
    if (w_class == ERR_DATA) o_flip[w_entry[5:0]] = 1'b1;
  end

  assign o_ce = (w_class == ERR_CHK) || (w_class == ERR_DATA);
  assign o_ue = (w_class == ERR_UNCORR);

endmodule

// File: rtl/sparc_exu_ecc_chk.sv
// Two-stage SEC-DED checker/corrector for the EXU register-file read path.
// Define SPARC_ECC_ERR_LOG_EN to build the saturating error counters and first-error log.
module sparc_exu_ecc_chk
  import sparc_ecc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_l,
  input  logic                se,
  sparc_exu_ecc_chk_if.slave  bus
);

  logic              w_unused_se;
  logic [15:0]       w_part;
  logic              r_s1_vld;
  logic [DATA_W-1:0] r_s1_d;
  logic [CHK_W-1:0]  r_s1_p;
  logic [15:0]       r_s1_part;
  logic [CHK_W-1:0]  w_pc;
  logic [6:0]        w_s_lo;
  logic              w_s7;
  logic [CHK_W-1:0]  w_syn;
  logic [DATA_W-1:0] w_flip;
  logic              w_ce;
  logic              w_ue;
  logic              r_vld;
  logic [DATA_W-1:0] r_d;
  logic [CHK_W-1:0]  r_syn;
  logic              r_ce;
  logic              r_ue;

  assign w_unused_se = se;

  // Split each parity tree into low/high 32-bit halves so stage 1 only has half the depth.
  always_comb begin
    w_part = '0;
    for (int k = 0; k < CHK_W; k++) begin
      w_part[2*k]   = ^(bus.d_in[31:0]  & PAR_MASK[k][31:0]);
      w_part[2*k+1] = ^(bus.d_in[63:32] & PAR_MASK[k][63:32]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) r_s1_vld <= 1'b0;
    else        r_s1_vld <= bus.vld_in;
  end

  // NOTE: stage-1 data flops carry no reset; r_s1_vld alone decides whether they matter.
  always_ff @(posedge clk) begin
    r_s1_d    <= bus.d_in;
    r_s1_p    <= bus.p_in;
    r_s1_part <= w_part;
  end

  always_comb begin
    w_pc = '0;
    for (int k = 0; k < CHK_W; k++) w_pc[k] = r_s1_part[2*k] ^ r_s1_part[2*k+1];
  end

  // Overall parity reduces to p7 mismatch corrected by the parity of the low syndrome.
  assign w_s_lo = w_pc[6:0] ^ r_s1_p[6:0];
  assign w_s7   = w_pc[7] ^ r_s1_p[7] ^ (^w_s_lo);
  assign w_syn  = {w_s7, w_s_lo};

  sparc_exu_ecc_syndec u_syndec (
    .i_syn  (w_syn),
    .o_flip (w_flip),
    .o_ce   (w_ce),
    .o_ue   (w_ue)
  );

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_vld <= 1'b0;
      r_d   <= '0;
      r_syn <= '0;
      r_ce  <= 1'b0;
      r_ue  <= 1'b0;
    end else begin
      r_vld <= r_s1_vld;
      r_d   <= r_s1_d ^ w_flip;
      r_syn <= w_syn;
      r_ce  <= r_s1_vld & w_ce;
      r_ue  <= r_s1_vld & w_ue;
    end
  end

  assign bus.vld_out = r_vld;
  assign bus.d_out   = r_d;
  assign bus.syn     = r_syn;
  assign bus.ce      = r_ce;
  assign bus.ue      = r_ue;

`ifdef SPARC_ECC_ERR_LOG_EN
  logic             w_cap_ce;
  logic             w_cap_ue;
  logic             r_log_vld;
  logic [CHK_W-1:0] r_log_syn;
  logic             r_log_ue;
  logic [7:0]       r_ce_cnt;
  logic [7:0]       r_ue_cnt;

  assign w_cap_ce = r_s1_vld & w_ce;
  assign w_cap_ue = r_s1_vld & w_ue;

  // A clear in the same cycle as a new error leaves exactly that error recorded.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_log_vld <= 1'b0;
      r_log_syn <= '0;
      r_log_ue  <= 1'b0;
      r_ce_cnt  <= '0;
      r_ue_cnt  <= '0;
    end else begin
      if (bus.log_clr) begin
        r_ce_cnt <= {7'd0, w_cap_ce};
        r_ue_cnt <= {7'd0, w_cap_ue};
      end else begin
        if (w_cap_ce && (r_ce_cnt != 8'hFF)) r_ce_cnt <= r_ce_cnt + 8'd1;
        if (w_cap_ue && (r_ue_cnt != 8'hFF)) r_ue_cnt <= r_ue_cnt + 8'd1;
      end

      if (w_cap_ue && (bus.log_clr || !(r_log_vld && r_log_ue))) begin
        r_log_vld <= 1'b1;
        r_log_syn <= w_syn;
        r_log_ue  <= 1'b1;
      end else if (w_cap_ce && (bus.log_clr || !r_log_vld)) begin
        r_log_vld <= 1'b1;
        r_log_syn <= w_syn;
        r_log_ue  <= 1'b0;
      end else if (bus.log_clr) begin
        r_log_vld <= 1'b0;
        r_log_syn <= '0;
        r_log_ue  <= 1'b0;
      end
    end
  end

  assign bus.log_vld = r_log_vld;
  assign bus.log_syn = r_log_syn;
  assign bus.log_ue  = r_log_ue;
  assign bus.ce_cnt  = r_ce_cnt;
  assign bus.ue_cnt  = r_ue_cnt;
`else
  logic w_unused_log_clr;
  assign w_unused_log_clr = bus.log_clr;

  assign bus.log_vld = 1'b0;
  assign bus.log_syn = '0;
  assign bus.log_ue  = 1'b0;
  assign bus.ce_cnt  = '0;
  assign bus.ue_cnt  = '0;
`endif

endmodule
